// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Memory-mapped 8N1 UART transmitter with a small write FIFO.
//             Bytes pushed by the bus side are queued and serialized
//             LSB-first on uart_txd at DIVISOR clocks per bit.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DIVISOR = 2604,  // clk_in cycles per bit, must be >= 2
  parameter int FIFO_AW = 2      // FIFO depth = 2**FIFO_AW
) (
  input  logic               clk_in,
  input  logic               sys_rstn,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic               err_clr,
  output logic               uart_txd,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               busy,
  output logic               tx_done,
  output logic               overflow,
  output logic               tx_irq
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam int               BW        = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [BW-1:0]    BAUD_LAST = BW'(DIVISOR - 1);
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  state_e             state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               ovf_q, ovf_d;

  // Combinational helpers
  logic               full;
  logic               push;
  logic               pop;
  logic               baud_end;
  logic               have_data;
  logic [7:0]         head;

  // Full and acceptance are judged only on registered occupancy, so a pop in
  // the same cycle never rescues a write that arrives while full.
  assign full      = (count_q == DEPTH_CNT);
  assign push      = wr_en & ~full;
  assign have_data = (count_q != '0);
  assign head      = mem_q[rptr_q];
  assign baud_end  = (baud_q == BAUD_LAST);

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  assign uart_txd   = txd_q;
  assign fifo_full  = full;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE);
  assign tx_done    = (state_q == STOP) && baud_end;
  assign overflow   = ovf_q;
  assign tx_irq     = ~have_data && (state_q == IDLE);

  // FIFO storage: data only, no reset needed since pointers gate every read.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  // FIFO pointer, occupancy and sticky overflow next-state logic.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) begin
      wptr_d = wptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + FIFO_AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (FIFO_AW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (FIFO_AW + 1)'(1);
    end
    // A dropped write in the same cycle as err_clr leaves the flag set.
    if (err_clr) begin
      ovf_d = 1'b0;
    end
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end
  end

  // Transmit FSM next-state: baud pacing, bit shifting and FIFO pops.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        txd_d  = 1'b1;
        if (have_data) begin
          pop     = 1'b1;
          shift_d = head;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            // Present the next bit together with the shift so the line
            // changes exactly on the bit boundary.
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (have_data) begin
            // Chain straight into the next start bit with no idle gap.
            pop     = 1'b1;
            shift_d = head;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any frame and forces the line high at once.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Directed self-checking bench for uart_tx_fifo; a fast instance
//             (DIVISOR=4) for frame, FIFO and overflow corners and a default
//             instance for full-rate bit timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic clk;
  logic rst_n;

  // Fast instance
  logic       s_wr_en, s_err_clr;
  logic [7:0] s_wr_data;
  logic       s_txd, s_full, s_busy, s_done, s_ovf, s_irq;
  logic [2:0] s_count;

  // Default-rate instance
  logic       b_wr_en, b_err_clr;
  logic [7:0] b_wr_data;
  logic       b_txd, b_full, b_busy, b_done, b_ovf, b_irq;
  logic [2:0] b_count;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line level per bit time: [0]=start .. [9]=stop
  } vec_t;

  vec_t vecs [4];

  uart_tx_fifo #(.DIVISOR(4), .FIFO_AW(2)) u_small (
    .clk_in    (clk),
    .sys_rstn  (rst_n),
    .wr_en     (s_wr_en),
    .wr_data   (s_wr_data),
    .err_clr   (s_err_clr),
    .uart_txd  (s_txd),
    .fifo_full (s_full),
    .fifo_count(s_count),
    .busy      (s_busy),
    .tx_done   (s_done),
    .overflow  (s_ovf),
    .tx_irq    (s_irq)
  );

  uart_tx_fifo u_big (
    .clk_in    (clk),
    .sys_rstn  (rst_n),
    .wr_en     (b_wr_en),
    .wr_data   (b_wr_data),
    .err_clr   (b_err_clr),
    .uart_txd  (b_txd),
    .fifo_full (b_full),
    .fifo_count(b_count),
    .busy      (b_busy),
    .tx_done   (b_done),
    .overflow  (b_ovf),
    .tx_irq    (b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called on the negedge of the first start-bit cycle (sample 0). Samples
  // already observed by the caller are skipped. Returns on the negedge of the
  // first cycle after the stop bit.
  task automatic frame_check(input bit big, input int div, input logic [9:0] f,
                             input int skip, input string name);
    int   done_bad;
    logic txd, done, exp_done;
    done_bad = 0;
    for (int b = 0; b < 10; b++) begin
      int bad;
      bad = 0;
      for (int j = 0; j < div; j++) begin
        if (b * div + j >= skip) begin
          txd      = big ? b_txd  : s_txd;
          done     = big ? b_done : s_done;
          exp_done = (b == 9) && (j == div - 1);
          if (txd !== f[b]) bad++;
          if (done !== exp_done) done_bad++;
          @(negedge clk);
        end
      end
      chk($sformatf("%s bit%0d bad_samples", name, b), 32'(bad), 0);
    end
    chk($sformatf("%s tx_done_bad_samples", name), 32'(done_bad), 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    s_wr_en   = 1'b0;
    s_wr_data = 8'h00;
    s_err_clr = 1'b0;
    b_wr_en   = 1'b0;
    b_wr_data = 8'h00;
    b_err_clr = 1'b0;

    vecs[0] = '{data: 8'h55, frame: 10'h2AA};
    vecs[1] = '{data: 8'h00, frame: 10'h200};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
    vecs[3] = '{data: 8'h80, frame: 10'h300};

    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    chk("rst txd",   32'(s_txd),   1);
    chk("rst busy",  32'(s_busy),  0);
    chk("rst done",  32'(s_done),  0);
    chk("rst ovf",   32'(s_ovf),   0);
    chk("rst count", 32'(s_count), 0);
    chk("rst full",  32'(s_full),  0);
    chk("rst irq",   32'(s_irq),   1);
    chk("rst big txd",   32'(b_txd),   1);
    chk("rst big busy",  32'(b_busy),  0);
    chk("rst big done",  32'(b_done),  0);
    chk("rst big ovf",   32'(b_ovf),   0);
    chk("rst big count", 32'(b_count), 0);
    chk("rst big full",  32'(b_full),  0);
    chk("rst big irq",   32'(b_irq),   1);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- single-byte frames from idle ----------------
    for (int i = 0; i < 4; i++) begin
      s_wr_en   = 1'b1;
      s_wr_data = vecs[i].data;
      @(negedge clk);
      s_wr_en = 1'b0;
      chk($sformatf("v%0d count after write", i), 32'(s_count), 1);
      chk($sformatf("v%0d txd before start", i), 32'(s_txd), 1);
      @(negedge clk);
      chk($sformatf("v%0d busy at start", i), 32'(s_busy), 1);
      chk($sformatf("v%0d count at start", i), 32'(s_count), 0);
      frame_check(1'b0, 4, vecs[i].frame, 0, $sformatf("v%0d", i));
      chk($sformatf("v%0d busy after", i), 32'(s_busy), 0);
      chk($sformatf("v%0d irq after", i), 32'(s_irq), 1);
      chk($sformatf("v%0d txd after", i), 32'(s_txd), 1);
    end

    // ---------------- back-to-back frames ----------------
    s_wr_en = 1'b1; s_wr_data = 8'hA5;
    @(negedge clk);
    chk("b2b count1", 32'(s_count), 1);
    s_wr_data = 8'h3C;
    @(negedge clk);                      // frame sample 0
    chk("b2b count2", 32'(s_count), 1);
    chk("b2b txd start", 32'(s_txd), 0);
    s_wr_data = 8'hFF;
    @(negedge clk);                      // frame sample 1
    s_wr_en = 1'b0;
    chk("b2b count3", 32'(s_count), 2);
    frame_check(1'b0, 4, 10'h34A, 1, "b2b A5");
    chk("b2b count after A5", 32'(s_count), 1);
    frame_check(1'b0, 4, 10'h278, 0, "b2b 3C");
    chk("b2b count after 3C", 32'(s_count), 0);
    frame_check(1'b0, 4, 10'h3FE, 0, "b2b FF");
    chk("b2b busy end", 32'(s_busy), 0);
    chk("b2b irq end", 32'(s_irq), 1);

    // ---------------- overflow and write-while-full-on-pop ----------------
    for (int i = 0; i < 6; i++) begin
      s_wr_en   = 1'b1;
      s_wr_data = 8'(8'h11 * (i + 1));
      @(negedge clk);
    end
    s_wr_en = 1'b0;                      // now at frame sample 4
    chk("ovf count", 32'(s_count), 4);
    chk("ovf full", 32'(s_full), 1);
    chk("ovf flag", 32'(s_ovf), 1);
    chk("ovf irq", 32'(s_irq), 0);
    s_err_clr = 1'b1;
    @(negedge clk);                      // sample 5
    s_err_clr = 1'b0;
    chk("ovf cleared", 32'(s_ovf), 0);
    chk("ovf still full", 32'(s_full), 1);
    repeat (4) @(negedge clk);           // sample 9
    s_wr_en = 1'b1; s_err_clr = 1'b1; s_wr_data = 8'h99;
    @(negedge clk);                      // sample 10
    s_wr_en = 1'b0; s_err_clr = 1'b0;
    chk("ovf set wins", 32'(s_ovf), 1);
    chk("ovf count held", 32'(s_count), 4);
    s_err_clr = 1'b1;
    @(negedge clk);                      // sample 11
    s_err_clr = 1'b0;
    chk("ovf cleared2", 32'(s_ovf), 0);
    repeat (28) @(negedge clk);          // sample 39, last stop cycle
    chk("pop edge done", 32'(s_done), 1);
    chk("pop edge count", 32'(s_count), 4);
    s_wr_en = 1'b1; s_wr_data = 8'h77;
    @(negedge clk);
    s_wr_en = 1'b0;
    chk("full+pop count", 32'(s_count), 3);
    chk("full+pop ovf", 32'(s_ovf), 1);
    chk("full+pop full", 32'(s_full), 0);
    chk("full+pop txd", 32'(s_txd), 0);
    frame_check(1'b0, 4, 10'h244, 0, "ovf 22");
    chk("ovf count after 22", 32'(s_count), 2);
    frame_check(1'b0, 4, 10'h266, 0, "ovf 33");
    frame_check(1'b0, 4, 10'h288, 0, "ovf 44");
    frame_check(1'b0, 4, 10'h2AA, 0, "ovf 55");
    chk("ovf drained busy", 32'(s_busy), 0);
    chk("ovf drained count", 32'(s_count), 0);
    s_err_clr = 1'b1;
    @(negedge clk);
    s_err_clr = 1'b0;

    // ---------------- reset in the middle of data bit 3 ----------------
    s_wr_en = 1'b1; s_wr_data = 8'hC3;
    @(negedge clk);
    s_wr_data = 8'h5A;
    @(negedge clk);                      // frame sample 0
    s_wr_en = 1'b0;
    chk("mid count", 32'(s_count), 1);
    repeat (17) @(negedge clk);          // sample 17, inside data bit 3
    chk("mid txd bit3", 32'(s_txd), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst txd", 32'(s_txd), 1);
    chk("mid rst busy", 32'(s_busy), 0);
    chk("mid rst count", 32'(s_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s_wr_en = 1'b1; s_wr_data = 8'h01;
    @(negedge clk);
    s_wr_en = 1'b0;
    chk("post rst count", 32'(s_count), 1);
    @(negedge clk);
    frame_check(1'b0, 4, 10'h202, 0, "post rst 01");
    chk("post rst idle", 32'(s_busy), 0);

    // ---------------- default divisor ----------------
    b_wr_en = 1'b1; b_wr_data = 8'h4D;
    @(negedge clk);
    b_wr_en = 1'b0;
    chk("big count", 32'(b_count), 1);
    @(negedge clk);
    chk("big busy", 32'(b_busy), 1);
    frame_check(1'b1, 2604, 10'h29A, 0, "big 4D");
    chk("big busy end", 32'(b_busy), 0);
    chk("big irq end", 32'(b_irq), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
